sd_spi: RTL and testbench

//  SPI master behind the Lision SD ports 0x0F/0x1F. Consumes sd_signal/sd_cmd/sd_out from the port decoder.

---
 rtl/sd_pkg.sv | 34 +++
 rtl/sd_spi_shifter.sv | 79 +++++++
 rtl/sd_spi.sv | 163 ++++++++++++++++
 tb/tb_sd_spi.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/sd_pkg.sv
// Shared definitions for the SD card SPI master: command encodings, FSM
// states and the CRC7 helper used when SD_CRC7_EN is defined.
package sd_pkg;

    localparam logic [1:0] SD_CMD_INIT   = 2'd0;
    localparam logic [1:0] SD_CMD_XFER   = 2'd1;
    localparam logic [1:0] SD_CMD_CS_ON  = 2'd2;
    localparam logic [1:0] SD_CMD_CS_OFF = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        XFER = 2'd2,
        DONE = 2'd3
    } sd_state_t;

    // x^7 + x^3 + 1 with the x^7 term implied
    localparam logic [6:0] CRC7_POLY = 7'h09;

    // Fold one byte, MSB first, into a running CRC7
    function automatic logic [6:0] crc7_byte(input logic [6:0] crc_in,
                                             input logic [7:0] data);
        logic [6:0] c;
        logic       fb;
        c = crc_in;
        for (int i = 7; i >= 0; i--) begin
            fb = c[6] ^ data[i];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ CRC7_POLY;
        end
        return c;
    endfunction

endpackage

// File: rtl/sd_spi_shifter.sv
// SCLK divider plus 8-bit shift register for the SD SPI master (mode 0,
// MSB first). A start pulse loads the byte and runs either 8 SCLK pulses
// (transfer) or INIT_CLOCKS pulses with MOSI held high (card wake-up).
// done is asserted combinationally on the cycle of the final falling edge.
module sd_spi_shifter
    import sd_pkg::*;
#(
    parameter int SPI_DIV     = 4,
    parameter int INIT_CLOCKS = 80
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start,
    input  logic       init_mode,
    input  logic [7:0] tx_byte,
    input  logic       miso,
    output logic       sclk,
    output logic       mosi,
    output logic       done,
    output logic [7:0] rx_byte
);

    localparam int MAX_PULSES = (INIT_CLOCKS > 8) ? INIT_CLOCKS : 8;
    localparam int HW         = $clog2(2 * MAX_PULSES);
    localparam int DW         = (SPI_DIV > 1) ? $clog2(SPI_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST  = DW'(SPI_DIV - 1);
    localparam logic [HW-1:0] INIT_LAST = HW'(2 * INIT_CLOCKS - 1);
    localparam logic [HW-1:0] XFER_LAST = HW'(15);

    logic          active;
    logic [DW-1:0] div_cnt;
    logic [HW-1:0] half_cnt;
    logic [HW-1:0] half_last;
    logic [7:0]    tx_q;
    logic [7:0]    rx_q;
    logic          wrap;

    assign wrap    = active && (div_cnt == DIV_LAST);
    assign done    = wrap && sclk && (half_cnt == half_last);
    assign mosi    = tx_q[7];
    // Final received byte including the bit captured on the last edge
    assign rx_byte = {rx_q[6:0], miso};

    // Divider and shifter. The synchronised MISO is taken at the end of the
    // SCLK-high phase: the two sync flops delay the pin by two cycles, so
    // this is the pin value just after the rising edge. MOSI advances on
    // the falling edge, refilling with 1s so the line rests high.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            active    <= 1'b0;
            sclk      <= 1'b0;
            div_cnt   <= '0;
            half_cnt  <= '0;
            half_last <= '0;
            tx_q      <= 8'hFF;
            rx_q      <= 8'hFF;
        end else if (start) begin
            active    <= 1'b1;
            sclk      <= 1'b0;
            div_cnt   <= '0;
            half_cnt  <= '0;
            half_last <= init_mode ? INIT_LAST : XFER_LAST;
            tx_q      <= init_mode ? 8'hFF : tx_byte;
        end else if (wrap) begin
            div_cnt  <= '0;
            sclk     <= ~sclk;
            half_cnt <= half_cnt + 1'b1;
            if (sclk) begin
                rx_q <= {rx_q[6:0], miso};
                tx_q <= {tx_q[6:0], 1'b1};
            end
            if (half_cnt == half_last) active <= 1'b0;
        end else if (active) begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/sd_spi.sv
// SPI master behind the SD data/control ports. Software runs the SD
// protocol; this block moves bytes, drives chip select and watches for a
// card that never answers. Define SD_CRC7_EN to add the sd_crc7 output,
// a CRC7 over every byte sent since the last CS_ON.
module sd_spi
    import sd_pkg::*;
#(
    parameter int SPI_DIV     = 4,
    parameter int INIT_CLOCKS = 80,
    parameter int TIMEOUT_CYC = 4000000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       sd_signal,
    input  logic [1:0] sd_cmd,
    input  logic [7:0] sd_out,
    output logic [7:0] sd_din,
    output logic       sd_busy,
    output logic       sd_timeout,
    output logic       spi_cs_n,
    output logic       spi_sclk,
    output logic       spi_mosi,
`ifdef SD_CRC7_EN
    output logic [6:0] sd_crc7,
`endif
    input  logic       spi_miso
);

    localparam int TW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [TW-1:0] WD_LIMIT = TW'(TIMEOUT_CYC);

    sd_state_t     state;
    sd_state_t     next_state;
    logic          miso_meta;
    logic          miso_sync;
    logic          shift_start;
    logic          shift_init;
    logic          shift_done;
    logic          shift_mosi;
    logic [7:0]    shift_rx;
    logic          accept;
    logic          xfer_end;
    logic          wd_clear;
    logic [TW-1:0] wd_cnt;

    assign sd_busy    = (state == INIT) || (state == XFER);
    assign accept     = sd_signal && !sd_busy;
    assign xfer_end   = (state == XFER) && shift_done;
    assign spi_mosi   = (state == XFER) ? shift_mosi : 1'b1;
    assign sd_timeout = (wd_cnt == WD_LIMIT);

    sd_spi_shifter #(
        .SPI_DIV    (SPI_DIV),
        .INIT_CLOCKS(INIT_CLOCKS)
    ) u_shifter (
        .clock    (clock),
        .reset_n  (reset_n),
        .start    (shift_start),
        .init_mode(shift_init),
        .tx_byte  (sd_out),
        .miso     (miso_sync),
        .sclk     (spi_sclk),
        .mosi     (shift_mosi),
        .done     (shift_done),
        .rx_byte  (shift_rx)
    );

    // Two-flop synchroniser for the card's MISO line
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            miso_meta <= 1'b1;
            miso_sync <= 1'b1;
        end else begin
            miso_meta <= spi_miso;
            miso_sync <= miso_meta;
        end
    end

    // FSM state register
    always_ff @(posedge clock) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    // Next state and shifter start; commands are taken whenever not busy
    always_comb begin
        next_state  = state;
        shift_start = 1'b0;
        shift_init  = 1'b0;
        case (state)
            IDLE, DONE: begin
                next_state = IDLE;
                if (accept) begin
                    if (sd_cmd == SD_CMD_INIT) begin
                        next_state  = INIT;
                        shift_start = 1'b1;
                        shift_init  = 1'b1;
                    end else if (sd_cmd == SD_CMD_XFER) begin
                        next_state  = XFER;
                        shift_start = 1'b1;
                    end
                end
            end
            INIT:    if (shift_done) next_state = DONE;
            XFER:    if (shift_done) next_state = DONE;
            default: next_state = IDLE;
        endcase
    end

    // Chip select: INIT always runs with the card deselected
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            spi_cs_n <= 1'b1;
        end else if (accept) begin
            case (sd_cmd)
                SD_CMD_INIT:   spi_cs_n <= 1'b1;
                SD_CMD_CS_ON:  spi_cs_n <= 1'b0;
                SD_CMD_CS_OFF: spi_cs_n <= 1'b1;
                default:       spi_cs_n <= spi_cs_n;
            endcase
        end
    end

    // Latch the received byte on the last falling edge of a transfer
    always_ff @(posedge clock) begin
        if (!reset_n)      sd_din <= 8'hFF;
        else if (xfer_end) sd_din <= shift_rx;
    end

    assign wd_clear = (accept && ((sd_cmd == SD_CMD_CS_ON) || (sd_cmd == SD_CMD_CS_OFF)))
                   || (xfer_end && (shift_rx != 8'hFF));

    // Watchdog: counts while selected, saturates, restarts on card activity
    always_ff @(posedge clock) begin
        if (!reset_n)                                wd_cnt <= '0;
        else if (wd_clear)                           wd_cnt <= '0;
        else if (!spi_cs_n && (wd_cnt != WD_LIMIT))  wd_cnt <= wd_cnt + 1'b1;
    end

`ifdef SD_CRC7_EN
    logic [7:0] crc_byte;
    logic       crc_pending;

    // Hold the outgoing byte; crc_pending marks the DONE cycle of an XFER
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            crc_byte    <= 8'h00;
            crc_pending <= 1'b0;
        end else begin
            if (accept && (sd_cmd == SD_CMD_XFER)) crc_byte <= sd_out;
            crc_pending <= xfer_end;
        end
    end

    // Running CRC7 over sent bytes, restarted by CS_ON
    always_ff @(posedge clock) begin
        if (!reset_n)                               sd_crc7 <= 7'h00;
        else if (accept && (sd_cmd == SD_CMD_CS_ON)) sd_crc7 <= 7'h00;
        else if (crc_pending)                       sd_crc7 <= crc7_byte(sd_crc7, crc_byte);
    end
`endif

endmodule

// File: tb/tb_sd_spi.sv
// Directed bench for sd_spi with a mode-0 card model and a scoreboard of
// expected received bytes. Define SD_CRC7_EN to also cover sd_crc7.
module tb_sd_spi;
    import sd_pkg::*;

    logic       clock     = 1'b0;
    logic       reset_n   = 1'b0;
    logic       sd_signal = 1'b0;
    logic [1:0] sd_cmd    = 2'd0;
    logic [7:0] sd_out    = 8'h00;
    logic [7:0] sd_din;
    logic       sd_busy;
    logic       sd_timeout;
    logic       spi_cs_n;
    logic       spi_sclk;
    logic       spi_mosi;
    logic       spi_miso;
`ifdef SD_CRC7_EN
    logic [6:0] sd_crc7;
`endif

    int tests  = 0;
    int failed = 0;
    logic [7:0] expq[$];

    // card model state
    logic [7:0] card_byte  = 8'hFF;
    int         card_base  = 0;
    int         card_idx;
    int         falls      = 0;
    int         rises      = 0;
    logic [7:0] card_rx    = 8'h00;
    int         cs_bad     = 0;
    int         mosi_bad   = 0;
    logic       init_watch = 1'b0;

    sd_spi #(
        .SPI_DIV    (2),
        .INIT_CLOCKS(80),
        .TIMEOUT_CYC(100)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .sd_signal (sd_signal),
        .sd_cmd    (sd_cmd),
        .sd_out    (sd_out),
        .sd_din    (sd_din),
        .sd_busy   (sd_busy),
        .sd_timeout(sd_timeout),
        .spi_cs_n  (spi_cs_n),
        .spi_sclk  (spi_sclk),
        .spi_mosi  (spi_mosi),
`ifdef SD_CRC7_EN
        .sd_crc7   (sd_crc7),
`endif
        .spi_miso  (spi_miso)
    );

    always #5 clock = ~clock;

    // card captures MOSI on rising SCLK
    always @(posedge spi_sclk) begin
        card_rx = {card_rx[6:0], spi_mosi};
        rises++;
    end

    // card advances its output bit on falling SCLK
    always @(negedge spi_sclk) falls++;

    // card presents bit 7 first, then idles high after the byte
    always_comb begin
        card_idx = falls - card_base;
        spi_miso = 1'b1;
        if (card_idx >= 0 && card_idx < 8) spi_miso = card_byte[3'(7 - card_idx)];
    end

    // during INIT the card must stay deselected with MOSI high
    always @(negedge clock) begin
        if (init_watch && sd_busy) begin
            if (spi_cs_n !== 1'b1) cs_bad++;
            if (spi_mosi !== 1'b1) mosi_bad++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] cmd, input logic [7:0] data);
        sd_signal = 1'b1;
        sd_cmd    = cmd;
        sd_out    = data;
        @(posedge clock);
        #1;
        sd_signal = 1'b0;
    endtask

    task automatic startXfer(input logic [7:0] card_val, input logic [7:0] tx_val);
        card_byte = card_val;
        card_base = falls;
        expq.push_back(card_val);
        applyStimulus(SD_CMD_XFER, tx_val);
    endtask

    task automatic waitIdle(output int cycles);
        cycles = 0;
        while (sd_busy === 1'b1 && cycles < 1000) begin
            tick(1);
            cycles++;
        end
    endtask

    task automatic finishXfer(input string tag, input int exp_cycles);
        int c;
        waitIdle(c);
        checkOutput({tag, "_busy_cycles"}, c, exp_cycles);
        if (expq.size() > 0) checkOutput({tag, "_sd_din"}, sd_din, expq.pop_front());
    endtask

`ifdef SD_CRC7_EN
    logic [7:0] cmd0_msg [5] = '{8'h40, 8'h00, 8'h00, 8'h00, 8'h00};
`endif

    initial begin
        int c;
        int r0;

        $display("[TB] reset");
        reset_n = 1'b0;
        tick(3);
        checkOutput("rst_cs_n", spi_cs_n, 1);
        checkOutput("rst_sclk", spi_sclk, 0);
        checkOutput("rst_mosi", spi_mosi, 1);
        checkOutput("rst_sd_din", sd_din, 8'hFF);
        checkOutput("rst_busy", sd_busy, 0);
        checkOutput("rst_timeout", sd_timeout, 0);
        reset_n = 1'b1;
        tick(2);

        $display("[TB] INIT");
        r0 = rises;
        init_watch = 1'b1;
        applyStimulus(SD_CMD_INIT, 8'h00);
        checkOutput("init_busy_start", sd_busy, 1);
        waitIdle(c);
        init_watch = 1'b0;
        checkOutput("init_busy_cycles", c, 320);
        checkOutput("init_rises", rises - r0, 80);
        checkOutput("init_cs_high", cs_bad, 0);
        checkOutput("init_mosi_high", mosi_bad, 0);
        checkOutput("init_sclk_low", spi_sclk, 0);

        $display("[TB] XFER 40 / A5");
        applyStimulus(SD_CMD_CS_ON, 8'h00);
        checkOutput("cs_on", spi_cs_n, 0);
        checkOutput("cs_on_busy", sd_busy, 0);
        r0 = rises;
        startXfer(8'hA5, 8'h40);
        finishXfer("xfer40", 32);
        checkOutput("xfer40_mosi_byte", card_rx, 8'h40);
        checkOutput("xfer40_rises", rises - r0, 8);
        checkOutput("xfer40_timeout", sd_timeout, 0);
        checkOutput("xfer40_sclk_low", spi_sclk, 0);

        $display("[TB] watchdog");
        applyStimulus(SD_CMD_CS_ON, 8'h00);
        tick(99);
        checkOutput("wd_cycle99", sd_timeout, 0);
        tick(1);
        checkOutput("wd_cycle100", sd_timeout, 1);
        tick(20);
        checkOutput("wd_cycle120", sd_timeout, 1);
        startXfer(8'h01, 8'hFF);
        finishXfer("xfer_rx01", 32);
        checkOutput("wd_cleared", sd_timeout, 0);

        $display("[TB] overlapping command");
        r0 = rises;
        startXfer(8'h5A, 8'hFF);
        tick(4);
        applyStimulus(SD_CMD_XFER, 8'h00);
        finishXfer("xfer_overlap", 27);
        tick(10);
        checkOutput("overlap_rises", rises - r0, 8);
        checkOutput("overlap_mosi_byte", card_rx, 8'hFF);
        checkOutput("overlap_busy_after", sd_busy, 0);

        $display("[TB] reset mid-transfer");
        card_byte = 8'hA5;
        card_base = falls;
        applyStimulus(SD_CMD_XFER, 8'h3C);
        tick(18);
        checkOutput("mid_sclk_high", spi_sclk, 1);
        checkOutput("mid_busy", sd_busy, 1);
        reset_n = 1'b0;
        tick(1);
        checkOutput("abort_sclk", spi_sclk, 0);
        checkOutput("abort_cs_n", spi_cs_n, 1);
        checkOutput("abort_busy", sd_busy, 0);
        checkOutput("abort_sd_din", sd_din, 8'hFF);
        checkOutput("abort_mosi", spi_mosi, 1);
        reset_n = 1'b1;
        tick(2);

`ifdef SD_CRC7_EN
        $display("[TB] CRC7 over CMD0");
        applyStimulus(SD_CMD_CS_ON, 8'h00);
        checkOutput("crc_cleared", sd_crc7, 7'h00);
        for (int i = 0; i < 5; i++) begin
            startXfer(8'hFF, cmd0_msg[i]);
            finishXfer("crc_xfer", 32);
        end
        tick(2);
        checkOutput("crc_cmd0", sd_crc7, 7'h4A);
`endif

        checkOutput("scoreboard_empty", expq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
